// File: rtl/turn_sequencer.sv
// Battleships turn sequencer: runs the shot/answer exchange between the local
// game logic, the own-ship board RAM and the board-to-board UART link.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no game running, waiting for start
// MY_TURN   | local player may fire
// SEND_SHOT | shot byte offered to UART TX
// WAIT_ANS  | waiting for opponent answer, timeout/resend armed
// OPP_TURN  | waiting for opponent shot byte
// LOOKUP    | latched shot address presented to board RAM, result sampled
// SEND_ANS  | answer byte offered to UART TX
// GAME_OVER | game ended, only start is honoured
module turn_sequencer #(
   parameter int unsigned GRID_N         = 10,
   parameter int unsigned SHIP_CELLS     = 17,
   parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       first_player,
   input  logic       fire_req,
   input  logic [7:0] fire_pos,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] board_addr,
   input  logic       board_rd_data,
   output logic       my_turn,
   output logic [1:0] answer,
   output logic       answer_valid,
   output logic [7:0] opp_shot_pos,
   output logic       opp_shot_valid,
   output logic       opp_shot_hit,
   output logic [4:0] my_hits,
   output logic [4:0] opp_hits,
   output logic       game_over,
   output logic       win,
   output logic       link_err
);

   localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES) > 27) ? $clog2(TIMEOUT_CYCLES) : 27;
   localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [4:0]    SHIP      = 5'(SHIP_CELLS);
   localparam logic [4:0]    GRID      = 5'(GRID_N);
   localparam logic [7:0]    RETRY_MAX = 8'(MAX_RETRY);
   localparam logic [7:0]    ANS_HIT   = 8'hA1;
   localparam logic [7:0]    ANS_MISS  = 8'hA0;

   typedef enum logic [2:0] {
      IDLE, MY_TURN, SEND_SHOT, WAIT_ANS, OPP_TURN, LOOKUP, SEND_ANS, GAME_OVER
   } state_t;

   state_t        state, state_nx;
   logic [7:0]    shot_pos;
   logic [TW-1:0] tmo_cnt;
   logic [7:0]    retry_cnt;
   logic [7:0]    retry_inc;
   logic [4:0]    my_hits_inc;
   logic [4:0]    opp_hits_inc;
   logic          hs, fire_ok, rx_shot_ok, rx_hit, rx_miss, tmo_exp, begin_game;

   assign hs           = tx_valid & tx_ready;
   assign fire_ok      = ({1'b0, fire_pos[7:4]} < GRID) && ({1'b0, fire_pos[3:0]} < GRID);
   assign rx_shot_ok   = ({1'b0, rx_data[7:4]} < GRID) && ({1'b0, rx_data[3:0]} < GRID);
   assign rx_hit       = rx_valid && (rx_data == ANS_HIT);
   assign rx_miss      = rx_valid && (rx_data == ANS_MISS);
   assign tmo_exp      = (tmo_cnt == '0);
   assign retry_inc    = retry_cnt + 8'd1;
   assign my_hits_inc  = (my_hits < SHIP) ? my_hits + 5'd1 : my_hits;
   assign opp_hits_inc = (opp_hits < SHIP) ? opp_hits + 5'd1 : opp_hits;
   assign begin_game   = start && ((state == IDLE) || (state == GAME_OVER));
   assign my_turn      = (state == MY_TURN);
   assign game_over    = (state == GAME_OVER);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state decode; an rx answer takes priority over a same-cycle timeout
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, GAME_OVER:
            if (start) state_nx = first_player ? MY_TURN : OPP_TURN;
         MY_TURN:
            if (fire_req && fire_ok) state_nx = SEND_SHOT;
         SEND_SHOT:
            if (hs) state_nx = WAIT_ANS;
         WAIT_ANS:
            if (rx_hit)       state_nx = (my_hits_inc == SHIP) ? GAME_OVER : MY_TURN;
            else if (rx_miss) state_nx = OPP_TURN;
            else if (tmo_exp) state_nx = (retry_inc <= RETRY_MAX) ? SEND_SHOT : IDLE;
         OPP_TURN:
            if (rx_valid && rx_shot_ok) state_nx = LOOKUP;
         LOOKUP:
            state_nx = SEND_ANS;
         SEND_ANS:
            if (hs) begin
               if (!opp_shot_hit)         state_nx = MY_TURN;
               else if (opp_hits == SHIP) state_nx = GAME_OVER;
               else                       state_nx = OPP_TURN;
            end
         default:
            state_nx = IDLE;
      endcase
   end

   // datapath: tx register, timers, hit counters and result flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_data        <= '0;
         tx_valid       <= 1'b0;
         board_addr     <= '0;
         answer         <= '0;
         answer_valid   <= 1'b0;
         opp_shot_pos   <= '0;
         opp_shot_valid <= 1'b0;
         opp_shot_hit   <= 1'b0;
         my_hits        <= '0;
         opp_hits       <= '0;
         win            <= 1'b0;
         link_err       <= 1'b0;
         shot_pos       <= '0;
         tmo_cnt        <= '0;
         retry_cnt      <= '0;
      end else begin
         answer_valid   <= 1'b0;
         opp_shot_valid <= 1'b0;

         if (begin_game) begin
            my_hits      <= '0;
            opp_hits     <= '0;
            retry_cnt    <= '0;
            answer       <= '0;
            win          <= 1'b0;
            opp_shot_pos <= '0;
            opp_shot_hit <= 1'b0;
         end

         if (state == MY_TURN && fire_req && fire_ok)
            shot_pos <= fire_pos;

         // byte is loaded once on entry and held untouched until accepted
         if (state == SEND_SHOT || state == SEND_ANS) begin
            if (!tx_valid) begin
               tx_valid <= 1'b1;
               tx_data  <= (state == SEND_SHOT) ? shot_pos
                                                : (opp_shot_hit ? ANS_HIT : ANS_MISS);
            end else if (tx_ready) begin
               tx_valid <= 1'b0;
            end
         end

         if (state == SEND_SHOT && hs)
            tmo_cnt <= TMO_LOAD;

         if (state == WAIT_ANS) begin
            if (rx_hit || rx_miss) begin
               answer       <= rx_hit ? 2'b10 : 2'b01;
               answer_valid <= 1'b1;
               retry_cnt    <= '0;
               if (rx_hit) begin
                  my_hits <= my_hits_inc;
                  if (my_hits_inc == SHIP) win <= 1'b1;
               end
            end else if (tmo_exp) begin
               retry_cnt <= retry_inc;
               if (retry_inc > RETRY_MAX) link_err <= 1'b1;
            end else begin
               tmo_cnt <= tmo_cnt - TW'(1);
            end
         end

         if (state == OPP_TURN && rx_valid && rx_shot_ok)
            board_addr <= rx_data;

         if (state == LOOKUP) begin
            opp_shot_valid <= 1'b1;
            opp_shot_pos   <= board_addr;
            opp_shot_hit   <= board_rd_data;
            if (board_rd_data) opp_hits <= opp_hits_inc;
         end
      end
   end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer; expected tx bytes go through a scoreboard queue.
module tb_turn_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, first_player = 1'b0, fire_req = 1'b0;
   logic [7:0] fire_pos = '0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic [7:0] board_addr;
   logic       board_rd_data = 1'b0;
   logic       my_turn;
   logic [1:0] answer;
   logic       answer_valid;
   logic [7:0] opp_shot_pos;
   logic       opp_shot_valid, opp_shot_hit;
   logic [4:0] my_hits, opp_hits;
   logic       game_over, win, link_err;
   logic [43:0] all_out;

   int total = 0;
   int bad   = 0;
   logic [7:0] tx_q[$];

   turn_sequencer #(
      .GRID_N(10), .SHIP_CELLS(2), .TIMEOUT_CYCLES(50), .MAX_RETRY(3)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .first_player(first_player),
      .fire_req(fire_req), .fire_pos(fire_pos),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .board_addr(board_addr), .board_rd_data(board_rd_data),
      .my_turn(my_turn), .answer(answer), .answer_valid(answer_valid),
      .opp_shot_pos(opp_shot_pos), .opp_shot_valid(opp_shot_valid),
      .opp_shot_hit(opp_shot_hit), .my_hits(my_hits), .opp_hits(opp_hits),
      .game_over(game_over), .win(win), .link_err(link_err)
   );

   assign all_out = {tx_data, tx_valid, board_addr, my_turn, answer, answer_valid,
                     opp_shot_pos, opp_shot_valid, opp_shot_hit, my_hits, opp_hits,
                     game_over, win, link_err};

   always #5 clk = ~clk;

   initial begin
      #300us;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fire(input logic [7:0] p);
      fire_pos = p;
      fire_req = 1'b1;
      step();
      fire_req = 1'b0;
   endtask

   task automatic rx_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      rx_data  = '0;
   endtask

   // wait (bounded) for tx_valid, pop the expected byte, compare, then accept it
   task automatic wait_tx(input string tag, input int budget);
      int n;
      logic [7:0] exp;
      n = 0;
      while (!tx_valid && n < budget) begin
         step();
         n++;
      end
      chk({tag, "_valid"}, 64'(tx_valid), 64'd1);
      exp = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
      chk({tag, "_data"}, 64'(tx_data), 64'(exp));
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
   endtask

   initial begin
      int n;
      #23;
      chk("reset_outputs", 64'(all_out), 64'd0);
      step();
      rst = 1'b0;
      step();

      // local shot, miss answer
      first_player = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_my_turn", 64'(my_turn), 64'd1);
      tx_q.push_back(8'h35);
      fire(8'h35);
      chk("send_shot_my_turn", 64'(my_turn), 64'd0);
      step();
      chk("fire_latency", 64'(tx_valid), 64'd1);
      wait_tx("shot35", 10);
      rx_byte(8'hA0);
      chk("miss_answer", 64'({answer_valid, answer}), 64'b101);
      chk("miss_my_turn", 64'(my_turn), 64'd0);
      step();
      chk("answer_pulse_end", 64'(answer_valid), 64'd0);

      // opponent hit, tx stalled for 10 cycles
      board_rd_data = 1'b1;
      rx_byte(8'h42);
      chk("board_addr", 64'(board_addr), 64'h42);
      step();
      chk("opp_shot", 64'({opp_shot_valid, opp_shot_hit, opp_shot_pos}), 64'h342);
      chk("opp_hits1", 64'(opp_hits), 64'd1);
      tx_q.push_back(8'hA1);
      step();
      chk("ans_latency", 64'(tx_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("tx_stall", 64'({tx_valid, tx_data}), 64'h1A1);
      end
      wait_tx("ansA1", 5);
      chk("stay_opp", 64'(my_turn), 64'd0);

      // opponent miss
      board_rd_data = 1'b0;
      rx_byte(8'h43);
      tx_q.push_back(8'hA0);
      wait_tx("ansA0", 5);
      chk("miss_gives_turn", 64'(my_turn), 64'd1);
      chk("opp_hits_still1", 64'(opp_hits), 64'd1);

      // out-of-range fire and dropped shot byte in MY_TURN
      fire(8'hA2);
      step();
      step();
      chk("bad_fire_no_tx", 64'({tx_valid, my_turn}), 64'b01);
      rx_byte(8'h11);
      chk("drop_rx_valid", 64'(opp_shot_valid), 64'd0);
      step();
      chk("drop_rx_state", 64'({opp_shot_valid, my_turn, board_addr}), 64'h143);

      // timeout and retry
      tx_q.push_back(8'h09);
      fire(8'h09);
      wait_tx("shot09", 5);
      for (int r = 1; r <= 3; r++) begin
         tx_q.push_back(8'h09);
         wait_tx($sformatf("resend%0d", r), 200);
         chk("no_link_err_yet", 64'(link_err), 64'd0);
      end
      n = 0;
      while (!link_err && n < 200) begin
         step();
         n++;
      end
      chk("link_err", 64'({link_err, my_turn, game_over, tx_valid}), 64'b1000);
      chk("timeout_span", 64'(n >= 45 && n <= 60), 64'd1);

      // win with two hits
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_clear", 64'({my_hits, opp_hits, answer, my_turn}), 64'd1);
      chk("link_err_sticky", 64'(link_err), 64'd1);
      tx_q.push_back(8'h00);
      fire(8'h00);
      wait_tx("shot00", 5);
      rx_byte(8'hA1);
      chk("hit_answer", 64'({answer_valid, answer, my_hits, my_turn}), 64'b1_10_00001_1);
      tx_q.push_back(8'h99);
      fire(8'h99);
      wait_tx("shot99", 5);
      rx_byte(8'hA1);
      chk("win", 64'({my_hits, game_over, win}), 64'b00010_1_1);
      fire(8'h11);
      rx_byte(8'hA1);
      step();
      chk("game_over_ignore", 64'({tx_valid, my_hits, game_over, my_turn}), 64'b0_00010_1_0);

      // new game from GAME_OVER, opponent first, reset mid-transfer
      first_player = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("new_game", 64'({my_hits, opp_hits, game_over, win, my_turn}), 64'd0);
      board_rd_data = 1'b1;
      rx_byte(8'h55);
      step();
      step();
      chk("pre_reset_tx", 64'({tx_valid, tx_data}), 64'h1A1);
      #2 rst = 1'b1;
      #1;
      chk("async_reset", 64'(all_out), 64'd0);
      step();
      rst = 1'b0;
      step();
      chk("after_reset", 64'(all_out), 64'd0);
      chk("scoreboard_empty", 64'(tx_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
